// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared encodings for the LSU memory-side controller.
// The load extension helper is used by the lane/extract logic.
package lsu_mem_ctrl_pkg;

    localparam int LSU_ROB_ID_W = 4;
    localparam int LSU_TIMEOUT  = 1024;

    typedef enum logic [1:0] {
        LS_BYTE = 2'd0,
        LS_HALF = 2'd1,
        LS_WORD = 2'd2,
        LS_ILL  = 2'd3
    } ls_size_e;

    typedef enum logic [1:0] {
        EXC_OK       = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_TIMEOUT  = 2'd2
    } ls_exc_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } lsu_state_e;

    // w is already shifted so the addressed byte sits in [7:0]
    function automatic logic [31:0] ext_load(logic [31:0] w, ls_size_e size, logic uns);
        case (size)
            LS_BYTE: return uns ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            LS_HALF: return uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request, result and data-memory port bundle of the LSU memory controller.
// slave = controller view; master = load/store buffer, CDB arbiter and memory side.
interface lsu_mem_ctrl_if #(
    parameter int ROB_ID_W = 4
);
    logic                req_valid_i;
    logic                req_ready_o;
    logic                req_is_store_i;
    logic [1:0]          req_size_i;
    logic                req_unsigned_i;
    logic [31:0]         req_addr_i;
    logic [31:0]         req_data_i;
    logic [ROB_ID_W-1:0] req_rob_id_i;

    logic                mem_req_o;
    logic                mem_we_o;
    logic [31:0]         mem_addr_o;
    logic [31:0]         mem_data_o;
    logic [3:0]          mem_sel_o;
    logic [31:0]         mem_data_i;
    logic                mem_valid_i;
    logic                mem_ready_i;

    logic                res_valid_o;
    logic [ROB_ID_W-1:0] res_rob_id_o;
    logic [31:0]         res_data_o;
    logic [1:0]          res_exc_o;

    modport slave (
        input  req_valid_i, req_is_store_i, req_size_i, req_unsigned_i,
               req_addr_i, req_data_i, req_rob_id_i,
               mem_data_i, mem_valid_i, mem_ready_i,
        output req_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o, mem_sel_o,
               res_valid_o, res_rob_id_o, res_data_o, res_exc_o
    );

    modport master (
        output req_valid_i, req_is_store_i, req_size_i, req_unsigned_i,
               req_addr_i, req_data_i, req_rob_id_i,
               mem_data_i, mem_valid_i, mem_ready_i,
        input  req_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o, mem_sel_o,
               res_valid_o, res_rob_id_o, res_data_o, res_exc_o
    );
endinterface

// File: rtl/lsu_mem_ctrl_align.sv
// Byte-lane select, store shift, load extract/extend and misalign detect.
// Purely combinational: zero latency, no backpressure.
module lsu_mem_ctrl_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [1:0]  offset,
    input  ls_size_e    size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);
    logic [4:0] shamt;

    assign shamt      = {offset, 3'b000};
    assign wdata_lane = wdata << shamt;
    assign rdata_ext  = ext_load(rdata >> shamt, size, is_unsigned);

    always_comb begin
        sel        = 4'b0000;
        misaligned = 1'b0;
        case (size)
            LS_BYTE: sel = 4'b0001 << offset;
            LS_HALF: begin
                sel        = 4'b0011 << {offset[1], 1'b0};
                misaligned = offset[0];
            end
            LS_WORD: begin
                sel        = 4'b1111;
                misaligned = (offset != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// One-at-a-time load/store controller for the single data-memory port.
// Result 3 cycles after accept (load), 2 (store), 1 (misaligned); holds mem_req_o while mem_ready_i is low.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int ROB_ID_W = LSU_ROB_ID_W,
    parameter int TIMEOUT  = LSU_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    lsu_mem_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e          state_q, state_d;
    logic [31:0]         addr_q, data_q, rdata_q, rdata_d;
    ls_size_e            size_q;
    logic                store_q, uns_q, killed_q, killed_d;
    logic [ROB_ID_W-1:0] rob_q;
    ls_exc_e             exc_q, exc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic        idle, ready, accept, mem_req, res_valid;
    logic [1:0]  a_offset;
    ls_size_e    a_size;
    logic [3:0]  sel;
    logic [31:0] wdata_lane, rdata_ext;
    logic        misaligned;

    assign idle  = (state_q == S_IDLE);
    assign ready = idle && !rst;

    // In IDLE the aligner checks the incoming request; otherwise it works on the latched one
    assign a_offset = idle ? bus.req_addr_i[1:0] : addr_q[1:0];
    assign a_size   = idle ? ls_size_e'(bus.req_size_i) : size_q;

    lsu_mem_ctrl_align u_align (
        .offset      (a_offset),
        .size        (a_size),
        .is_unsigned (uns_q),
        .wdata       (data_q),
        .rdata       (bus.mem_data_i),
        .sel         (sel),
        .wdata_lane  (wdata_lane),
        .rdata_ext   (rdata_ext),
        .misaligned  (misaligned)
    );

    always_comb begin
        state_d  = state_q;
        exc_d    = exc_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        killed_d = killed_q;
        accept   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i && ready && (bus.req_is_store_i || !flush_i)) begin
                    accept   = 1'b1;
                    killed_d = 1'b0;
                    cnt_d    = '0;
                    rdata_d  = '0;
                    exc_d    = misaligned ? EXC_MISALIGN : EXC_OK;
                    state_d  = misaligned ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.mem_ready_i) state_d = store_q ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_valid_i) begin
                    rdata_d = rdata_ext;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    exc_d   = EXC_TIMEOUT;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Killed loads still finish the bus handshake; only the result is dropped
        if (flush_i && !store_q && !idle) killed_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            exc_q    <= EXC_OK;
            rdata_q  <= '0;
            cnt_q    <= '0;
            killed_q <= 1'b0;
            addr_q   <= '0;
            size_q   <= LS_BYTE;
            data_q   <= '0;
            rob_q    <= '0;
            store_q  <= 1'b0;
            uns_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            exc_q    <= exc_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            killed_q <= killed_d;
            if (accept) begin
                addr_q  <= bus.req_addr_i;
                size_q  <= ls_size_e'(bus.req_size_i);
                data_q  <= bus.req_data_i;
                rob_q   <= bus.req_rob_id_i;
                store_q <= bus.req_is_store_i;
                uns_q   <= bus.req_unsigned_i;
            end
        end
    end

    assign mem_req   = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign res_valid = (state_q == S_RESP) && !killed_q && (store_q || !flush_i);

    assign bus.req_ready_o  = ready;
    assign bus.mem_req_o    = mem_req;
    assign bus.mem_we_o     = mem_req && store_q;
    assign bus.mem_addr_o   = mem_req ? {addr_q[31:2], 2'b00} : '0;
    assign bus.mem_sel_o    = mem_req ? sel : '0;
    assign bus.mem_data_o   = (mem_req && store_q) ? wdata_lane : '0;
    assign bus.res_valid_o  = res_valid;
    assign bus.res_rob_id_o = res_valid ? rob_q : '0;
    assign bus.res_data_o   = res_valid ? rdata_q : '0;
    assign bus.res_exc_o    = res_valid ? exc_q : EXC_OK;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed-vector bench for lsu_mem_ctrl plus hand sequences for stall, flush and timeout.
module tb_lsu_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.ROB_ID_W(4)) bus();

    lsu_mem_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // Single-word RAM behind the port, written with byte lanes
    logic [31:0] ram_word = 32'h0;
    int          writes   = 0;
    always @(posedge clk) begin
        if (bus.mem_req_o && bus.mem_we_o && bus.mem_ready_i) begin
            writes <= writes + 1;
            for (int b = 0; b < 4; b++)
                if (bus.mem_sel_o[b]) ram_word[8*b +: 8] <= bus.mem_data_o[8*b +: 8];
        end
    end

    typedef struct packed {
        logic        st;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdword;
        logic        exp_req;
        logic [3:0]  exp_sel;
        logic [31:0] exp_wlane;
        logic [31:0] exp_res;
        logic [1:0]  exp_exc;
        logic [3:0]  lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] rob);
        @(negedge clk);
        if (!bus.req_ready_o) @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_is_store_i = st;
        bus.req_size_i     = sz;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = a;
        bus.req_data_i     = d;
        bus.req_rob_id_i   = rob;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit issued;
        bit got;
        issued = 1'b0;
        got    = 1'b0;
        bus.mem_ready_i = 1'b1;
        bus.mem_valid_i = 1'b0;
        bus.mem_data_i  = v.rdword;
        send(v.st, v.sz, v.uns, v.addr, v.wdata, 4'(idx + 1));
        for (int cyc = 1; cyc <= 10 && !got; cyc++) begin
            @(negedge clk);
            if (bus.mem_req_o && !issued) begin
                issued = 1'b1;
                chk($sformatf("v%0d issue_cycle", idx), 32'(cyc), 32'd1);
                chk($sformatf("v%0d we", idx), 32'(bus.mem_we_o), 32'(v.st));
                chk($sformatf("v%0d addr", idx), bus.mem_addr_o, v.addr & 32'hFFFF_FFFC);
                chk($sformatf("v%0d sel", idx), 32'(bus.mem_sel_o), 32'(v.exp_sel));
                if (v.st) chk($sformatf("v%0d wdata", idx), bus.mem_data_o, v.exp_wlane);
            end
            if (bus.res_valid_o) begin
                got = 1'b1;
                chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.lat));
                chk($sformatf("v%0d res_data", idx), bus.res_data_o, v.exp_res);
                chk($sformatf("v%0d res_exc", idx), 32'(bus.res_exc_o), 32'(v.exp_exc));
                chk($sformatf("v%0d rob", idx), 32'(bus.res_rob_id_o), 32'(idx + 1));
            end
            bus.mem_valid_i = issued && !v.st && bus.mem_req_o && (cyc >= 2);
        end
        bus.mem_valid_i = 1'b0;
        chk($sformatf("v%0d result_seen", idx), 32'(got), 32'd1);
        chk($sformatf("v%0d mem_req_seen", idx), 32'(issued), 32'(v.exp_req));
    endtask

    initial begin
        int lat;
        int last_req;
        int w0;
        bit seen;

        //           st sz   uns addr          wdata          rdword         req sel    wlane          res            exc  lat
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0,        1'b1, 4'hF, 32'hDEADBEEF, 32'h0,        2'd0, 4'd2};
        vecs[1]  = '{1'b1, 2'd0, 1'b0, 32'h103, 32'h000000AB, 32'h0,        1'b1, 4'h8, 32'hAB000000, 32'h0,        2'd0, 4'd2};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'h80FF7F01, 1'b1, 4'h8, 32'h0,        32'hFFFFFF80, 2'd0, 4'd3};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        32'h80FF7F01, 1'b1, 4'h8, 32'h0,        32'h00000080, 2'd0, 4'd3};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h102, 32'h0,        32'h80FF7F01, 1'b1, 4'hC, 32'h0,        32'hFFFF80FF, 2'd0, 4'd3};
        vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        32'h80FF7F01, 1'b1, 4'hC, 32'h0,        32'h000080FF, 2'd0, 4'd3};
        vecs[6]  = '{1'b0, 2'd0, 1'b0, 32'h100, 32'h0,        32'h80FF7F01, 1'b1, 4'h1, 32'h0,        32'h00000001, 2'd0, 4'd3};
        vecs[7]  = '{1'b0, 2'd0, 1'b0, 32'h101, 32'h0,        32'h80FF7F01, 1'b1, 4'h2, 32'h0,        32'h0000007F, 2'd0, 4'd3};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h104, 32'h0,        32'h80FF7F01, 1'b1, 4'hF, 32'h0,        32'h80FF7F01, 2'd0, 4'd3};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h102, 32'h0,        32'h80FF7F01, 1'b0, 4'h0, 32'h0,        32'h0,        2'd1, 4'd1};
        vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h101, 32'h0,        32'h80FF7F01, 1'b0, 4'h0, 32'h0,        32'h0,        2'd1, 4'd1};
        vecs[11] = '{1'b0, 2'd3, 1'b0, 32'h100, 32'h0,        32'h80FF7F01, 1'b0, 4'h0, 32'h0,        32'h0,        2'd1, 4'd1};
        vecs[12] = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h00001234, 32'h0,        1'b1, 4'hC, 32'h12340000, 32'h0,        2'd0, 4'd2};

        bus.req_valid_i    = 1'b0;
        bus.req_is_store_i = 1'b0;
        bus.req_size_i     = 2'd0;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = 32'h0;
        bus.req_data_i     = 32'h0;
        bus.req_rob_id_i   = 4'h0;
        bus.mem_data_i     = 32'h0;
        bus.mem_valid_i    = 1'b0;
        bus.mem_ready_i    = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst req_ready", 32'(bus.req_ready_o), 32'd0);
        chk("rst mem_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst mem_sel", 32'(bus.mem_sel_o), 32'd0);
        chk("rst res_valid", 32'(bus.res_valid_o), 32'd0);
        chk("rst res_exc", 32'(bus.res_exc_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst req_ready", 32'(bus.req_ready_o), 32'd1);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], i);
            if (i == 1) chk("ram after SB", ram_word, 32'hABADBEEF);
        end

        // Load presented together with flush is refused
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_is_store_i = 1'b0; bus.req_size_i = 2'd2;
        bus.req_addr_i = 32'h100; flush = 1'b1;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flushed load req_ready", 32'(bus.req_ready_o), 32'd1);
        chk("flushed load mem_req", 32'(bus.mem_req_o), 32'd0);

        // Store is accepted and acknowledged despite flush
        flush = 1'b1;
        send(1'b1, 2'd2, 1'b0, 32'h10C, 32'h11223344, 4'd9);
        @(negedge clk);
        chk("flush store mem_req", 32'(bus.mem_req_o), 32'd1);
        chk("flush store we", 32'(bus.mem_we_o), 32'd1);
        @(negedge clk);
        chk("flush store ack", 32'(bus.res_valid_o), 32'd1);
        flush = 1'b0;

        // Flush during WAIT: handshake completes, no result
        bus.mem_ready_i = 1'b1; bus.mem_valid_i = 1'b0; bus.mem_data_i = 32'h12345678;
        send(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 4'd5);
        seen = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (bus.res_valid_o) seen = 1'b1;
            if (cyc == 4 || cyc == 5) chk($sformatf("killed mem_req c%0d", cyc), 32'(bus.mem_req_o), 32'd1);
            if (cyc == 6) chk("killed mem_req drop", 32'(bus.mem_req_o), 32'd0);
            flush = (cyc == 3);
            bus.mem_valid_i = (cyc == 5);
        end
        flush = 1'b0; bus.mem_valid_i = 1'b0;
        chk("killed load no result", 32'(seen), 32'd0);
        run_vec(vecs[2], 2);

        // Flush arriving in RESP suppresses the load pulse
        bus.mem_data_i = 32'h80FF7F01;
        send(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 4'd6);
        @(negedge clk);
        @(negedge clk);
        bus.mem_valid_i = 1'b1;
        @(posedge clk);
        #1 flush = 1'b1; bus.mem_valid_i = 1'b0;
        @(negedge clk);
        chk("resp flush res_valid", 32'(bus.res_valid_o), 32'd0);
        flush = 1'b0;

        // Store stalled by mem_ready_i low for 5 cycles
        bus.mem_ready_i = 1'b0;
        w0 = writes;
        send(1'b1, 2'd2, 1'b0, 32'h108, 32'h00000055, 4'd7);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            chk($sformatf("stall mem_req c%0d", cyc), 32'(bus.mem_req_o), 32'd1);
        end
        chk("stall no write", 32'(writes - w0), 32'd0);
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        chk("stall ack", 32'(bus.res_valid_o), 32'd1);
        chk("stall single write", 32'(writes - w0), 32'd1);
        chk("stall mem_req drop", 32'(bus.mem_req_o), 32'd0);

        // Bus timeout: no mem_valid_i ever
        bus.mem_valid_i = 1'b0;
        send(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 4'd8);
        lat = 0;
        last_req = 0;
        for (int cyc = 1; cyc <= 1200 && lat == 0; cyc++) begin
            @(negedge clk);
            if (bus.mem_req_o) last_req = cyc;
            if (bus.res_valid_o) begin
                lat = cyc;
                chk("timeout exc", 32'(bus.res_exc_o), 32'd2);
            end
        end
        chk("timeout latency", 32'(lat), 32'd1026);
        chk("timeout last mem_req", 32'(last_req), 32'd1025);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
